// File: rtl/bit_converter_arbiter.sv
// rtl/bit_converter_arbiter.sv - round-robin arbiter sharing one bit converter among lanes
//
// Purpose: accepts one 8-bit activation per cycle from NUM_LANES requesters
// (round-robin), forwards non-zero values to a shared BitConverterFIFO, keeps
// a {lane, popcount} tag per value and returns the converter's bit places on a
// single tagged output stream.
//
// Ports:
//   CLK, RSTN                      clock (rising edge), sync active-low reset
//   ReqValid/ReqData/ReqReady      per-lane requests; ReqReady one-hot grant
//   ActValuesFIFOWrite*            value write port into the converter
//   ActBitPlacesFIFORead*          show-ahead bit-place read port of the converter
//   OutValid/OutReady              output beat handshake
//   OutLane/OutBitPlace            owner lane and bit position of the beat
//   OutLast/OutZero                final beat of a value / value was 0x00
module bit_converter_arbiter #(
  parameter int NUM_LANES = 4,
  parameter int TAG_DEPTH = 8,
  parameter int LANE_W    = $clog2(NUM_LANES)
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic [NUM_LANES-1:0]   ReqValid,
  input  logic [8*NUM_LANES-1:0] ReqData,
  output logic [NUM_LANES-1:0]   ReqReady,
  output logic [7:0]             ActValuesFIFOWriteDataIn,
  output logic                   ActValuesFIFOWriteEnable,
  input  logic                   ActValuesFIFOWriteReady,
  input  logic [2:0]             ActBitPlacesFIFOReadDataOut,
  input  logic                   ActBitPlacesFIFOReadReady,
  output logic                   ActBitPlacesFIFOReadEnable,
  output logic                   OutValid,
  output logic [LANE_W-1:0]      OutLane,
  output logic [2:0]             OutBitPlace,
  output logic                   OutLast,
  output logic                   OutZero,
  input  logic                   OutReady
);

  localparam int PTR_W = $clog2(TAG_DEPTH);

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

  logic [LANE_W-1:0] rr;
  logic [LANE_W-1:0] tag_lane [TAG_DEPTH];
  logic [3:0]        tag_cnt  [TAG_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic [3:0]        idx;

  logic [LANE_W-1:0] cand;
  logic [LANE_W-1:0] probe;
  logic              cand_found;
  logic [7:0]        cand_data;
  logic              tag_full;
  logic              tag_empty;
  logic              accept;
  logic [LANE_W-1:0] head_lane;
  logic [3:0]        head_cnt;
  logic              head_zero;
  logic              handshake;
  logic              pop;

  // Search from rr upwards; LANE_W-bit addition wraps because NUM_LANES is a power of two.
  always_comb begin
    cand       = '0;
    probe      = '0;
    cand_found = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      probe = rr + LANE_W'(i);
      if (!cand_found && ReqValid[probe]) begin
        cand       = probe;
        cand_found = 1'b1;
      end
    end
  end

  assign cand_data = ReqData[{cand, 3'b000} +: 8];
  assign tag_full  = (count == (PTR_W+1)'(TAG_DEPTH));
  assign tag_empty = (count == '0);

  // Zero values never touch the converter, so they ignore its write-ready.
  assign accept = RSTN && cand_found && !tag_full &&
                  (ActValuesFIFOWriteReady || (cand_data == 8'h00));

  assign ReqReady                 = accept ? (NUM_LANES'(1) << cand) : '0;
  assign ActValuesFIFOWriteEnable = accept && (cand_data != 8'h00);
  assign ActValuesFIFOWriteDataIn = ActValuesFIFOWriteEnable ? cand_data : 8'h00;

  assign head_lane = tag_lane[rd_ptr];
  assign head_cnt  = tag_cnt[rd_ptr];
  assign head_zero = (head_cnt == 4'd0);

  // A zero-value tag produces its single beat without the converter.
  assign OutValid    = RSTN && !tag_empty && (head_zero || ActBitPlacesFIFOReadReady);
  assign OutLane     = head_lane;
  assign OutZero     = !tag_empty && head_zero;
  assign OutBitPlace = head_zero ? 3'd0 : ActBitPlacesFIFOReadDataOut;
  assign OutLast     = head_zero || (idx == 4'(head_cnt - 4'd1));

  assign handshake                  = OutValid && OutReady;
  assign ActBitPlacesFIFOReadEnable = handshake && !head_zero;
  assign pop                        = handshake && OutLast;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      rr     <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      idx    <= '0;
    end else begin
      if (accept) begin
        tag_lane[wr_ptr] <= cand;
        tag_cnt[wr_ptr]  <= popcount8(cand_data);
        wr_ptr           <= wr_ptr + PTR_W'(1);
        rr               <= cand + LANE_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        idx    <= '0;
      end else if (handshake) begin
        idx <= idx + 4'd1;
      end
      case ({accept, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_converter_arbiter.sv
// tb/tb_bit_converter_arbiter.sv - self-checking bench for bit_converter_arbiter
module tb_bit_converter_arbiter;

  localparam int NL = 4;
  localparam int TD = 8;

  logic          CLK = 1'b0;
  logic          RSTN;
  logic [NL-1:0] ReqValid;
  logic [8*NL-1:0] ReqData;
  logic [NL-1:0] ReqReady;
  logic [7:0]    ActValuesFIFOWriteDataIn;
  logic          ActValuesFIFOWriteEnable;
  logic          ActValuesFIFOWriteReady;
  logic [2:0]    ActBitPlacesFIFOReadDataOut;
  logic          ActBitPlacesFIFOReadReady;
  logic          ActBitPlacesFIFOReadEnable;
  logic          OutValid;
  logic [1:0]    OutLane;
  logic [2:0]    OutBitPlace;
  logic          OutLast;
  logic          OutZero;
  logic          OutReady;

  bit_converter_arbiter #(.NUM_LANES(NL), .TAG_DEPTH(TD)) dut (
    .CLK(CLK), .RSTN(RSTN), .ReqValid(ReqValid), .ReqData(ReqData), .ReqReady(ReqReady),
    .ActValuesFIFOWriteDataIn(ActValuesFIFOWriteDataIn),
    .ActValuesFIFOWriteEnable(ActValuesFIFOWriteEnable),
    .ActValuesFIFOWriteReady(ActValuesFIFOWriteReady),
    .ActBitPlacesFIFOReadDataOut(ActBitPlacesFIFOReadDataOut),
    .ActBitPlacesFIFOReadReady(ActBitPlacesFIFOReadReady),
    .ActBitPlacesFIFOReadEnable(ActBitPlacesFIFOReadEnable),
    .OutValid(OutValid), .OutLane(OutLane), .OutBitPlace(OutBitPlace),
    .OutLast(OutLast), .OutZero(OutZero), .OutReady(OutReady)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [NL-1:0]   valid;
    logic [8*NL-1:0] data;
    logic            wr_ready;
    logic [NL-1:0]   exp_ready;
    logic            exp_we;
    logic [7:0]      exp_wdata;
  } vec_t;

  typedef struct {
    int       lane;
    bit [7:0] data;
  } tag_t;

  int checks = 0;
  int errors = 0;

  // Reference model: values in flight, converter contents, pointer, beat index.
  tag_t     tag_q[$];
  bit [2:0] conv_q[$];
  int       rr_m;
  int       bidx;
  bit       stall_en;
  bit       conv_show;

  // Per-step observations used by the directed sequences.
  int acc_cnt, beat_cnt, last_cnt;
  bit m_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nth_bit(input bit [7:0] d, input int n);
    int c = 0;
    for (int b = 0; b < 8; b++) begin
      if (d[b]) begin
        if (c == n) return b;
        c++;
      end
    end
    return 0;
  endfunction

  function automatic int popc(input bit [7:0] d);
    int c = 0;
    for (int b = 0; b < 8; b++) c += int'(d[b]);
    return c;
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    RSTN = 1'b0;
    ReqValid = '1;
    ReqData = 32'hFF01_0203;
    ActValuesFIFOWriteReady = 1'b1;
    ActBitPlacesFIFOReadReady = 1'b1;
    ActBitPlacesFIFOReadDataOut = 3'd5;
    OutReady = 1'b1;
    #1;
    chk("rst_req_ready", ReqReady, 0);
    chk("rst_write_en", ActValuesFIFOWriteEnable, 0);
    chk("rst_out_valid", OutValid, 0);
    chk("rst_read_en", ActBitPlacesFIFOReadEnable, 0);
    tag_q.delete();
    conv_q.delete();
    rr_m = 0;
    bidx = 0;
  endtask

  task automatic step(input logic [NL-1:0] v, input logic [8*NL-1:0] d,
                      input logic wr_rdy, input logic out_rdy);
    int g;
    bit found, acc, ev, ez, el;
    bit [7:0] gd;
    int ebp, elane;
    logic [NL-1:0] eready;
    @(negedge CLK);
    RSTN = 1'b1;
    ReqValid = v;
    ReqData = d;
    ActValuesFIFOWriteReady = wr_rdy;
    OutReady = out_rdy;
    conv_show = (conv_q.size() > 0) && (!stall_en || ($urandom_range(0, 3) != 0));
    ActBitPlacesFIFOReadReady = conv_show;
    ActBitPlacesFIFOReadDataOut = conv_show ? conv_q[0] : 3'($urandom_range(0, 7));
    #1;
    found = 0; g = 0;
    for (int i = 0; i < NL; i++) begin
      int l = (rr_m + i) % NL;
      if (!found && v[l]) begin found = 1; g = l; end
    end
    gd = d[8*g +: 8];
    acc = found && (tag_q.size() < TD) && (wr_rdy || gd == 8'h00);
    eready = acc ? (NL'(1) << g) : '0;
    chk("req_ready", ReqReady, eready);
    chk("write_en", ActValuesFIFOWriteEnable, acc && gd != 0);
    chk("write_data", ActValuesFIFOWriteDataIn, (acc && gd != 0) ? gd : 8'h00);
    ev = 0; ez = 0; el = 0; ebp = 0; elane = 0;
    if (tag_q.size() > 0) begin
      elane = tag_q[0].lane;
      if (tag_q[0].data == 0) begin
        ev = 1; ez = 1; el = 1; ebp = 0;
      end else begin
        ev = conv_show;
        ebp = nth_bit(tag_q[0].data, bidx);
        el = (bidx == popc(tag_q[0].data) - 1);
      end
    end
    chk("out_valid", OutValid, ev);
    if (ev) begin
      chk("out_lane", OutLane, elane);
      chk("out_zero", OutZero, ez);
      chk("out_last", OutLast, el);
      chk("out_bit_place", OutBitPlace, ebp);
    end
    chk("read_en", ActBitPlacesFIFOReadEnable, ev && out_rdy && !ez);
    m_acc = acc;
    if (ev && out_rdy) begin
      beat_cnt++;
      if (el) begin
        last_cnt++;
        void'(tag_q.pop_front());
        bidx = 0;
      end else begin
        bidx++;
      end
      if (!ez) void'(conv_q.pop_front());
    end
    if (acc) begin
      tag_t t;
      acc_cnt++;
      t.lane = g;
      t.data = gd;
      tag_q.push_back(t);
      for (int b = 0; b < 8; b++) if (gd[b]) conv_q.push_back(3'(b));
      rr_m = (g + 1) % NL;
    end
  endtask

  task automatic clr_counts();
    acc_cnt = 0; beat_cnt = 0; last_cnt = 0;
  endtask

  vec_t vecs[8];

  initial begin
    RSTN = 1'b0; ReqValid = '0; ReqData = '0; OutReady = 1'b0;
    ActValuesFIFOWriteReady = 1'b0; ActBitPlacesFIFOReadReady = 1'b0;
    ActBitPlacesFIFOReadDataOut = '0; stall_en = 0;
    rr_m = 0; bidx = 0;
    clr_counts();

    vecs[0] = '{4'b0001, 32'h0000_0011, 1'b1, 4'b0001, 1'b1, 8'h11};
    vecs[1] = '{4'b0000, 32'h1234_5678, 1'b1, 4'b0000, 1'b0, 8'h00};
    vecs[2] = '{4'b1010, 32'h4433_2211, 1'b1, 4'b0010, 1'b1, 8'h22};
    vecs[3] = '{4'b1000, 32'h8000_0000, 1'b0, 4'b0000, 1'b0, 8'h00};
    vecs[4] = '{4'b0100, 32'h0000_0000, 1'b0, 4'b0100, 1'b0, 8'h00};
    vecs[5] = '{4'b1111, 32'h0102_0304, 1'b1, 4'b0001, 1'b1, 8'h04};
    vecs[6] = '{4'b1100, 32'hFF00_0000, 1'b0, 4'b0100, 1'b0, 8'h00};
    vecs[7] = '{4'b1100, 32'hFF11_0000, 1'b0, 4'b0000, 1'b0, 8'h00};

    for (int i = 0; i < 8; i++) begin
      do_reset();
      @(negedge CLK);
      RSTN = 1'b1;
      ReqValid = vecs[i].valid;
      ReqData = vecs[i].data;
      ActValuesFIFOWriteReady = vecs[i].wr_ready;
      ActBitPlacesFIFOReadReady = 1'b0;
      OutReady = 1'b0;
      #1;
      chk($sformatf("vec%0d_ready", i), ReqReady, vecs[i].exp_ready);
      chk($sformatf("vec%0d_we", i), ActValuesFIFOWriteEnable, vecs[i].exp_we);
      chk($sformatf("vec%0d_wdata", i), ActValuesFIFOWriteDataIn, vecs[i].exp_wdata);
      chk($sformatf("vec%0d_out_valid", i), OutValid, 0);
    end

    // Lane 0 sends 0x11: two beats, places 0 then 4.
    do_reset(); clr_counts();
    step(4'b0001, 32'h0000_0011, 1, 1);
    for (int i = 0; i < 5; i++) step('0, '0, 1, 1);
    chk("s1_beats", beat_cnt, 2);
    chk("s1_lasts", last_cnt, 1);

    // Lane 2 sends 0x00: single zero beat.
    clr_counts();
    step(4'b0100, 32'h0000_0000, 0, 1);
    for (int i = 0; i < 3; i++) step('0, '0, 1, 1);
    chk("s2_beats", beat_cnt, 1);

    // All lanes valid with 0x01.
    do_reset(); clr_counts();
    for (int i = 0; i < 12; i++) step(4'b1111, 32'h0101_0101, 1, 1);
    for (int i = 0; i < 4; i++) step('0, '0, 1, 1);
    chk("s3_accepts", acc_cnt, 12);
    chk("s3_beats", beat_cnt, 12);

    // Output stalled: tag FIFO fills at 8 values of 0x03.
    do_reset(); clr_counts();
    for (int i = 0; i < 12; i++) step(4'b0010, 32'h0000_0300, 1, 0);
    chk("s4_accepts_full", acc_cnt, 8);
    chk("s4_stalled_ready", ReqReady, 0);
    clr_counts();
    for (int i = 0; i < 18; i++) step('0, '0, 1, 1);
    chk("s4_drain_beats", beat_cnt, 16);
    step(4'b0010, 32'h0000_0300, 1, 1);
    chk("s4_resume", m_acc, 1);

    // Converter not ready: non-zero candidate blocks; zero lane passes once rr=1.
    do_reset(); clr_counts();
    step(4'b0011, 32'h0000_0080, 0, 1);
    chk("s5_blocked", m_acc, 0);
    step(4'b0001, 32'h0000_0000, 0, 1);
    chk("s5_prime", m_acc, 1);
    step(4'b0011, 32'h0000_0080, 0, 1);
    chk("s5_lane1_ready", ReqReady, 4'b0010);
    for (int i = 0; i < 3; i++) step('0, '0, 1, 1);

    // Reset with 3 tags pending, then 0xFF.
    do_reset(); clr_counts();
    for (int i = 0; i < 3; i++) step(4'b0001, 32'h0000_0005, 1, 0);
    chk("s6_pending", acc_cnt, 3);
    do_reset(); clr_counts();
    step(4'b1001, 32'hFF00_00FF, 1, 1);
    chk("s6_rr_zero", ReqReady, 4'b0001);
    for (int i = 0; i < 12; i++) step('0, '0, 1, 1);
    chk("s6_beats", beat_cnt, 8);
    chk("s6_lasts", last_cnt, 1);

    // Randomized traffic against the model, with one mid-run reset.
    stall_en = 1;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [8*NL-1:0] rd;
      for (int l = 0; l < NL; l++)
        rd[8*l +: 8] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      if (c == 1500) do_reset();
      step(NL'($urandom), rd, $urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_converter_arbiter.md
# bit_converter_arbiter

Shares one `BitConverterFIFO` between `NUM_LANES` activation requesters. Values are accepted round-robin, one per cycle at most, and forwarded to the converter. For each value the block records a tag (lane ID and popcount) in an internal tag FIFO. Bit places read back from the converter are returned on a single output stream, tagged with the originating lane and a last-of-value marker. It sits between the per-lane activation buffers and the shared converter.

## Interface
- `NUM_LANES`, 4: number of requesters; power of two, minimum 2.
- `TAG_DEPTH`, 8: tag FIFO entries; power of two; caps the number of values in flight.
- `LANE_W`, $clog2(NUM_LANES): lane ID width.

Ports:
- `CLK` in 1: clock, rising edge.
- `RSTN` in 1: reset, synchronous, active-low.
- `ReqValid` in NUM_LANES: per-lane value valid.
- `ReqData` in 8*NUM_LANES: per-lane 8-bit activation; lane i occupies bits [8i+7:8i].
- `ReqReady` out NUM_LANES: one-hot; lane i's value is accepted this cycle.
- `ActValuesFIFOWriteDataIn` out 8: value written to the converter.
- `ActValuesFIFOWriteEnable` out 1: converter write strobe.
- `ActValuesFIFOWriteReady` in 1: converter can accept a write.
- `ActBitPlacesFIFOReadDataOut` in 3: head bit place from the converter (show-ahead).
- `ActBitPlacesFIFOReadReady` in 1: converter output is non-empty.
- `ActBitPlacesFIFOReadEnable` out 1: pops the converter head.
- `OutValid` out 1: output beat valid.
- `OutLane` out LANE_W: lane that owns the beat.
- `OutBitPlace` out 3: bit position; 0 when `OutZero`.
- `OutLast` out 1: final beat of the current value.
- `OutZero` out 1: the value was 0x00; no bit places exist.
- `OutReady` in 1: downstream accepts the beat.

## Operation
- State:
  - round-robin pointer `rr` (LANE_W bits);
  - tag FIFO, TAG_DEPTH entries of {lane, popcount[3:0]};
  - beat index `idx` (4 bits).
- Grant:
  - Search `ReqValid` starting at `rr`, wrapping NUM_LANES-1 to 0. The first set lane is the candidate `g`.
  - Accept `g` when the tag FIFO is not full, and either `ActValuesFIFOWriteReady`=1 or `ReqData[g]`=0.
  - On accept: `ReqReady[g]`=1 (combinational), push {g, popcount(ReqData[g])}, and set `rr` to g+1 (mod NUM_LANES) at the next edge.
- Forwarding:
  - On accept with non-zero data: `ActValuesFIFOWriteEnable`=1 and `ActValuesFIFOWriteDataIn`=`ReqData[g]`.
  - Zero values are never written to the converter. Otherwise `ActValuesFIFOWriteDataIn`=0.
- Converter contract: a non-zero value with popcount k yields exactly k bit places, in order. Values are emitted in write order, so the tag FIFO head always matches the converter head.
- Return path, head tag {L, C}:
  - C=0: `OutValid`=1, `OutZero`=1, `OutLast`=1, `OutBitPlace`=0, `OutLane`=L. On handshake, pop the tag. No converter read.
  - C>0: `OutValid`=`ActBitPlacesFIFOReadReady`, `OutBitPlace`=`ActBitPlacesFIFOReadDataOut`, `OutLast`=(idx==C-1).
  - `ActBitPlacesFIFOReadEnable`=`OutValid`&`OutReady`&!`OutZero`.
  - On handshake: if `OutLast`, pop the tag and clear `idx`; otherwise increment `idx`.
- Tag FIFO:
  - When full, no accept occurs, even if a pop happens in the same cycle.
  - Push and pop in the same cycle are allowed when not full.
  - Read and write pointers wrap modulo TAG_DEPTH. An occupancy counter of log2(TAG_DEPTH)+1 bits distinguishes full from empty.
- Popcount is 4 bits, range 0..8. `idx` never exceeds 7.

## Timing
- Reset (`RSTN`=0 at an edge): `rr`=0, tag FIFO empty, `idx`=0. During and after reset:
  - `OutValid`=0;
  - `ActBitPlacesFIFOReadEnable`=0;
  - `ActValuesFIFOWriteEnable`=0 unless a request is presented after reset.
  - While `RSTN`=0, force `ReqReady`=0 and `ActValuesFIFOWriteEnable`=0.
- Reset mid-operation discards all tags. The converter must be reset on the same `RSTN` to stay aligned.
- Request to converter write: 0 cycles (combinational).
- Zero value to output beat: 1 cycle after accept at the earliest, since the tag becomes visible after the push edge.
- Non-zero values: the output beat follows as soon as the tag is visible and `ActBitPlacesFIFOReadReady`=1.
- Output holds all fields stable while `OutValid`=1 and `OutReady`=0.
- Throughput: one accept per cycle and one output beat per cycle.

## Test plan
- Lane 0 sends 0x11, `OutReady`=1 → converter write of 0x11. Two beats, lane 0, `OutLast`=0 then 1. Bit places 0 and 4 in converter order.
- Lane 2 sends 0x00 → no converter write. One beat: `OutLane`=2, `OutZero`=1, `OutLast`=1, `OutBitPlace`=0.
- All 4 lanes valid continuously with 0x01 → accept order 0,1,2,3,0,1… Output lanes appear in the same order, one beat each.
- `OutReady`=0 while lane 1 streams 0x03 → exactly 8 accepts, then `ReqReady`=0. After `OutReady`=1, all 16 beats drain and accepts resume.
- `ActValuesFIFOWriteReady`=0, lane 0 = 0x80, lane 1 = 0x00, `rr`=0 → no accept. Set `rr`=1 → lane 1 (zero) is accepted.
- Reset asserted with 3 tags pending → after the edge, `OutValid`=0, `rr`=0. Next value 0xFF yields 8 beats, the last flagged.
